// File: rtl/regfile_pkg.sv
// regfile_pkg: sweep FSM state encoding and default geometry for regfile_mp
package regfile_pkg;
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;
   localparam int DWIDTH_DEF = 32;
   localparam int AWIDTH_DEF = 5;
   localparam int DEPTH_DEF  = 32;
   localparam int NRD_DEF    = 2;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write ports, read ports and ready of regfile_mp
interface regfile_mp_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5,
   parameter int NRD    = 2
);
   logic                   ready;
   logic                   we0, we1;
   logic [AWIDTH-1:0]      wa0, wa1;
   logic [DWIDTH-1:0]      wd0, wd1;
   logic [NRD*AWIDTH-1:0]  ra;
   logic [NRD*DWIDTH-1:0]  rd;
   modport master (input ready, rd, output we0, wa0, wd0, we1, wa1, wd1, ra);
   modport slave  (output ready, rd, input we0, wa0, wd0, we1, wa1, wd1, ra);
endinterface

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: after reset, sweeps zeros into entries 1..DEPTH-1 and then raises ready
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready_o,
   output logic              clr_we_o,
   output logic [AWIDTH-1:0] clr_addr_o
);
   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
   state_t            state_q;
   logic [AWIDTH-1:0] ptr_q;
   logic              ready_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         ptr_q   <= AWIDTH'(1);
         ready_q <= 1'b0;
      end else if (state_q == ST_CLEAR) begin
         ptr_q <= ptr_q + AWIDTH'(1);
         if (ptr_q == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
         end
      end
   end
   assign ready_o    = ready_q;
   assign clr_we_o   = state_q == ST_CLEAR;
   assign clr_addr_o = ptr_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD async read / 2 sync write register file, x0 hardwired to zero, post-reset clear.
// Define REGFILE_MP_BYPASS_EN for write-first read bypass in RUN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int NRD    = NRD_DEF
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);
   logic                  ready, clr_we, w0_en, w1_en;
   logic [AWIDTH-1:0]     clr_addr, w1_a;
   logic [DWIDTH-1:0]     w1_d;
   logic [DWIDTH-1:0]     mem_q [1:DEPTH-1];
   logic [NRD*DWIDTH-1:0] rd_c;

   regfile_clear_fsm #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .ready_o    (ready),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // the sweep borrows port 1 so it wins over any user write
   always_comb begin
      w0_en = ready & bus.we0;
      w1_en = clr_we | (ready & bus.we1);
      w1_a  = clr_we ? clr_addr : bus.wa1;
      w1_d  = clr_we ? '0 : bus.wd1;
   end

   always_ff @(posedge clk) begin
      for (int e = 1; e < DEPTH; e++) begin
         if (w1_en && w1_a == AWIDTH'(e)) mem_q[e] <= w1_d;
         else if (w0_en && bus.wa0 == AWIDTH'(e)) mem_q[e] <= bus.wd0;
      end
   end

   // only addresses 1..DEPTH-1 match an entry, so x0 and out-of-range read zero
   always_comb begin
      rd_c = '0;
      for (int p = 0; p < NRD; p++) begin
         for (int e = 1; e < DEPTH; e++) begin
            if (ready && bus.ra[p*AWIDTH +: AWIDTH] == AWIDTH'(e)) begin
               rd_c[p*DWIDTH +: DWIDTH] = mem_q[e];
`ifdef REGFILE_MP_BYPASS_EN
               if (bus.we0 && bus.wa0 == AWIDTH'(e)) rd_c[p*DWIDTH +: DWIDTH] = bus.wd0;
               if (bus.we1 && bus.wa1 == AWIDTH'(e)) rd_c[p*DWIDTH +: DWIDTH] = bus.wd1;
`endif
            end
         end
      end
   end

   assign bus.rd    = rd_c;
   assign bus.ready = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of regfile_mp against an array reference model
module tb_regfile_mp;
   localparam int DW = 32, AW = 5, DEP = 32, NR = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW), .NRD(NR)) bus ();
   regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEP), .NRD(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [DW-1:0] mdl [0:DEP-1];
   logic          mrdy = 1'b0;
   int            total = 0, bad = 0;

   task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(logic e0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                        logic e1, logic [AW-1:0] a1, logic [DW-1:0] d1);
      bus.we0 = e0; bus.wa0 = a0; bus.wd0 = d0;
      bus.we1 = e1; bus.wa1 = a1; bus.wd1 = d1;
   endtask

   task automatic set_ra(int p, logic [AW-1:0] a);
      bus.ra[p*AW +: AW] = a;
   endtask

   task automatic rand_in(bit narrow);
      drive(1'($urandom), narrow ? AW'($urandom_range(0, 7)) : AW'($urandom), $urandom,
            1'($urandom), narrow ? AW'($urandom_range(0, 7)) : AW'($urandom), $urandom);
      for (int p = 0; p < NR; p++) set_ra(p, narrow ? AW'($urandom_range(0, 7)) : AW'($urandom));
   endtask

   function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
      if (!mrdy || a == 0 || int'(a) >= DEP) return '0;
`ifdef REGFILE_MP_BYPASS_EN
      if (bus.we1 && bus.wa1 == a) return bus.wd1;
      if (bus.we0 && bus.wa0 == a) return bus.wd0;
`endif
      return mdl[a];
   endfunction

   task automatic check_reads(string tag);
      #1;
      for (int p = 0; p < NR; p++) chk(tag, bus.rd[p*DW +: DW], exp_rd(bus.ra[p*AW +: AW]));
   endtask

   task automatic step();
      @(posedge clk);
      if (mrdy) begin
         if (bus.we0 && bus.wa0 != 0) mdl[bus.wa0] = bus.wd0;
         if (bus.we1 && bus.wa1 != 0) mdl[bus.wa1] = bus.wd1;
      end
      @(negedge clk);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      mrdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic sweep(string tag, int edges);
      for (int k = 1; k <= edges; k++) begin
         rand_in(1'b0);
         check_reads({tag, "_rd"});
         @(posedge clk);
         #1;
         chk({tag, "_ready"}, DW'(bus.ready), DW'(k == DEP - 1));
         @(negedge clk);
      end
      if (edges == DEP - 1) begin
         for (int a = 0; a < DEP; a++) mdl[a] = '0;
         mrdy = 1'b1;
      end
   endtask

   task automatic read_all(string tag);
      drive(0, 0, 0, 0, 0, 0);
      for (int a = 0; a < DEP; a++) begin
         set_ra(0, AW'(a));
         set_ra(1, AW'(DEP - 1 - a));
         check_reads(tag);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      bus.ra = '0;
      @(negedge clk);
      pulse_rst();
      sweep("sweep", DEP - 1);
      read_all("after_clear");

      drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
      step();
      drive(0, 0, 0, 0, 0, 0);
      set_ra(0, 5); set_ra(1, 0);
      check_reads("wr5");
      chk("wr5_direct", bus.rd[DW-1:0], 32'hDEADBEEF);
      chk("x0_direct", bus.rd[DW +: DW], 32'h0);

      drive(1, 7, 32'h1, 1, 7, 32'h2);
      step();
      drive(0, 0, 0, 0, 0, 0);
      set_ra(0, 7); set_ra(1, 7);
      check_reads("prio7");
      chk("prio7_direct", bus.rd[DW-1:0], 32'h2);

      drive(0, 0, 0, 1, 0, 32'hFFFFFFFF);
      step();
      read_all("x0_write");

      drive(0, 0, 0, 1, 3, 32'hA5A5A5A5);
      set_ra(0, 3); set_ra(1, 5);
      check_reads("bypass3");
`ifdef REGFILE_MP_BYPASS_EN
      chk("bypass3_direct", bus.rd[DW-1:0], 32'hA5A5A5A5);
`else
      chk("bypass3_direct", bus.rd[DW-1:0], 32'h0);
`endif
      step();
      drive(0, 0, 0, 0, 0, 0);
      check_reads("after3");

      for (int n = 0; n < 300; n++) begin
         rand_in(n[0]);
         check_reads("rand");
         step();
      end

      drive(0, 0, 0, 1, 20, 32'h55);
      step();
      drive(0, 0, 0, 0, 0, 0);
      set_ra(0, 20);
      check_reads("r20_set");
      pulse_rst();
      sweep("part", 10);
      pulse_rst();
      sweep("resweep", DEP - 1);
      set_ra(0, 20);
      drive(0, 0, 0, 0, 0, 0);
      check_reads("r20_clear");
      chk("r20_direct", bus.rd[DW-1:0], 32'h0);
      read_all("after_resweep");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
